// File: rtl/packet_assembler.sv
// Transmit-side packet assembler: builds EER-RL packets (header, IDs, payload, checksum)
// and streams them as words over valid/ready, fetching data payloads from byte memory.
module packet_assembler #(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned MAX_DATA_WORDS = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  tx_start,
  input  logic [2:0]            tx_pkt_type,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] tx_destID,
  input  logic [WORD_WIDTH-1:0] tx_energy,
  input  logic [WORD_WIDTH-1:0] tx_qValue,
  input  logic [WORD_WIDTH-1:0] tx_hops,
  input  logic [ADDR_WIDTH-1:0] tx_data_base,
  input  logic [5:0]            tx_data_words,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned TYPE_W = 3;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PAD_W  = WORD_WIDTH - TYPE_W - LEN_W;

  localparam logic [TYPE_W-1:0] TYPE_HB   = 3'b000;
  localparam logic [TYPE_W-1:0] TYPE_CH   = 3'b001;
  localparam logic [TYPE_W-1:0] TYPE_JOIN = 3'b010;
  localparam logic [TYPE_W-1:0] TYPE_DATA = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SRC,
    DST,
    PAY,
    FETCH_HI,
    FETCH_LO,
    CSUM
  } state_e;

  // Request fields captured when a packet is accepted
  typedef struct packed {
    logic [TYPE_W-1:0]     pkt_type;
    logic [LEN_W-1:0]      len;
    logic [WORD_WIDTH-1:0] src;
    logic [WORD_WIDTH-1:0] dst;
    logic [WORD_WIDTH-1:0] energy;
    logic [WORD_WIDTH-1:0] qvalue;
    logic [WORD_WIDTH-1:0] hops;
  } req_t;

  state_e                state_q, state_d;
  req_t                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      idx_q, idx_d;
  logic [BYTE_W-1:0]     hi_q, hi_d;
  logic [WORD_WIDTH-1:0] sum_q, sum_d;
  logic [WORD_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_last_q, tx_last_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  start_illegal_c;
  logic                  is_data_c;
  logic                  xfer_c;
  logic [LEN_W-1:0]      next_idx_c;
  logic [WORD_WIDTH-1:0] sum_next_c;
  logic [LEN_W-1:0]      start_len_c;

  function automatic logic [LEN_W-1:0] pay_len(input logic [TYPE_W-1:0] t,
                                                input logic [5:0]        words);
    logic [LEN_W-1:0] l;
    case (t)
      TYPE_HB:   l = LEN_W'(2);
      TYPE_CH:   l = LEN_W'(3);
      TYPE_JOIN: l = LEN_W'(1);
      default:   l = LEN_W'(words);
    endcase
    return l;
  endfunction

  // Fixed-field payload word at position idx for the non-data packet types
  function automatic logic [WORD_WIDTH-1:0] pay_word(input req_t             r,
                                                      input logic [LEN_W-1:0] idx);
    logic [WORD_WIDTH-1:0] w;
    w = r.energy;
    case (r.pkt_type)
      TYPE_HB: begin
        if (idx == LEN_W'(1)) w = r.hops;
      end
      TYPE_CH: begin
        if (idx == LEN_W'(1)) w = r.qvalue;
        else if (idx == LEN_W'(2)) w = r.hops;
      end
      default: w = r.energy;
    endcase
    return w;
  endfunction

  assign start_illegal_c = tx_pkt_type[2]
                         | ((tx_pkt_type == TYPE_DATA)
                            & ((tx_data_words == 6'd0)
                               | (32'(tx_data_words) > MAX_DATA_WORDS)));
  assign is_data_c   = (req_q.pkt_type == TYPE_DATA);
  assign xfer_c      = tx_valid_q & tx_ready;
  assign next_idx_c  = idx_q + LEN_W'(1);
  assign sum_next_c  = sum_q + tx_data_q;
  assign start_len_c = pay_len(tx_pkt_type, tx_data_words);

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    hi_d       = hi_q;
    sum_d      = sum_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          if (start_illegal_c) begin
            err_d = 1'b1;
          end else begin
            req_d.pkt_type = tx_pkt_type;
            req_d.len      = start_len_c;
            req_d.src      = myNodeID;
            req_d.dst      = tx_destID;
            req_d.energy   = tx_energy;
            req_d.qvalue   = tx_qValue;
            req_d.hops     = tx_hops;
            addr_d         = tx_data_base;
            idx_d          = '0;
            sum_d          = '0;
            busy_d         = 1'b1;
            tx_valid_d     = 1'b1;
            tx_last_d      = 1'b0;
            tx_data_d      = WORD_WIDTH'({tx_pkt_type, {PAD_W{1'b0}}, start_len_c});
            state_d        = HDR;
          end
        end
      end
      HDR: begin
        if (xfer_c) begin
          sum_d     = sum_next_c;
          tx_data_d = req_q.src;
          state_d   = SRC;
        end
      end
      SRC: begin
        if (xfer_c) begin
          sum_d     = sum_next_c;
          tx_data_d = req_q.dst;
          state_d   = DST;
        end
      end
      DST: begin
        if (xfer_c) begin
          sum_d = sum_next_c;
          if (is_data_c) begin
            tx_valid_d = 1'b0;
            mem_rd_d   = 1'b1;
            mem_addr_d = addr_q;
            state_d    = FETCH_HI;
          end else begin
            tx_data_d = pay_word(req_q, '0);
            state_d   = PAY;
          end
        end
      end
      FETCH_HI: begin
        mem_rd_d   = 1'b1;
        mem_addr_d = addr_q + ADDR_WIDTH'(1);
        state_d    = FETCH_LO;
      end
      FETCH_LO: begin
        hi_d    = mem_rdata;
        addr_d  = addr_q + ADDR_WIDTH'(2);
        state_d = PAY;
      end
      PAY: begin
        // Data words enter PAY invalid; the low byte arrives this cycle
        if (is_data_c && !tx_valid_q) begin
          tx_data_d  = WORD_WIDTH'({hi_q, mem_rdata});
          tx_valid_d = 1'b1;
        end else if (xfer_c) begin
          sum_d = sum_next_c;
          idx_d = next_idx_c;
          if (next_idx_c == req_q.len) begin
            tx_data_d = sum_next_c;
            tx_last_d = 1'b1;
            state_d   = CSUM;
          end else if (is_data_c) begin
            tx_valid_d = 1'b0;
            mem_rd_d   = 1'b1;
            mem_addr_d = addr_q;
            state_d    = FETCH_HI;
          end else begin
            tx_data_d = pay_word(req_q, next_idx_c);
          end
        end
      end
      CSUM: begin
        if (xfer_c) begin
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      addr_q     <= '0;
      idx_q      <= '0;
      hi_q       <= '0;
      sum_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      hi_q       <= hi_d;
      sum_q      <= sum_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_packet_assembler.sv
// Scoreboard bench for packet_assembler: expected words are queued at request time and
// popped by a monitor as the DUT transfers them.
`timescale 1ns/1ps
module tb_packet_assembler;

  localparam int unsigned AW = 11;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          tx_start = 1'b0;
  logic [2:0]    tx_pkt_type = '0;
  logic [15:0]   myNodeID = '0;
  logic [15:0]   tx_destID = '0;
  logic [15:0]   tx_energy = '0;
  logic [15:0]   tx_qValue = '0;
  logic [15:0]   tx_hops = '0;
  logic [AW-1:0] tx_data_base = '0;
  logic [5:0]    tx_data_words = '0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = '0;
  logic [15:0]   tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          tx_last;
  logic          busy;
  logic          done;
  logic          err;

  packet_assembler dut (
    .clk(clk), .nrst(nrst), .tx_start(tx_start), .tx_pkt_type(tx_pkt_type),
    .myNodeID(myNodeID), .tx_destID(tx_destID), .tx_energy(tx_energy),
    .tx_qValue(tx_qValue), .tx_hops(tx_hops), .tx_data_base(tx_data_base),
    .tx_data_words(tx_data_words), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:2047];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] rd_addrs[$];
  int            checks = 0;
  int            failures = 0;

  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic          prev_last = 1'b0;
  logic [15:0]   prev_data = '0;

  // Monitor: hold-stability and scoreboard pop on each transfer
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!nrst) begin
      prev_valid = 1'b0;
    end else begin
      if (mem_rd === 1'b1) rd_addrs.push_back(mem_addr);
      if (prev_valid && !prev_ready) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data || tx_last !== prev_last) begin
          failures++;
          $display("FAIL hold_stable: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                   tx_valid, tx_data, tx_last, prev_data, prev_last);
        end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: data=%h last=%b required no transfer", tx_data, tx_last);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e.data || tx_last !== e.last) begin
            failures++;
            $display("FAIL tx_word: data=%h last=%b required data=%h last=%b",
                     tx_data, tx_last, e.data, e.last);
          end
        end
      end
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
      prev_last  = tx_last;
    end
  end

  // Reference model: queue every word of a packet, checksum included
  task automatic push_pkt(input logic [2:0] t, input logic [15:0] id, input logic [15:0] dst,
                          input logic [15:0] en, input logic [15:0] qv, input logic [15:0] hops,
                          input logic [AW-1:0] base, input int words);
    logic [15:0]   pl[$];
    logic [15:0]   all[$];
    logic [15:0]   sum;
    logic [AW-1:0] a;
    logic [7:0]    hi;
    logic [7:0]    lo;
    logic [7:0]    len;
    case (t)
      3'b000: begin pl.push_back(en); pl.push_back(hops); end
      3'b001: begin pl.push_back(en); pl.push_back(qv); pl.push_back(hops); end
      3'b010: pl.push_back(en);
      default: begin
        a = base;
        for (int i = 0; i < words; i++) begin
          hi = mem[a]; a = a + 1'b1;
          lo = mem[a]; a = a + 1'b1;
          pl.push_back({hi, lo});
        end
      end
    endcase
    len = 8'(pl.size());
    all.push_back({t, 5'b00000, len});
    all.push_back(id);
    all.push_back(dst);
    foreach (pl[i]) all.push_back(pl[i]);
    sum = '0;
    foreach (all[i]) begin
      sum = sum + all[i];
      exp_q.push_back({all[i], 1'b0});
    end
    exp_q.push_back({sum, 1'b1});
  endtask

  // Called at posedge+1; start is sampled on the next edge, then inputs are scrambled
  task automatic start_req(input logic [2:0] t, input logic [15:0] id, input logic [15:0] dst,
                           input logic [15:0] en, input logic [15:0] qv, input logic [15:0] hops,
                           input logic [AW-1:0] base, input logic [5:0] words);
    tx_pkt_type = t; myNodeID = id; tx_destID = dst; tx_energy = en;
    tx_qValue = qv; tx_hops = hops; tx_data_base = base; tx_data_words = words;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    tx_pkt_type = 3'b010; myNodeID = ~id; tx_destID = ~dst; tx_energy = ~en;
    tx_qValue = ~qv; tx_hops = ~hops; tx_data_base = ~base; tx_data_words = ~words;
  endtask

  // mode 0: ready always, 1: toggle 1/0, 2: random
  task automatic run_until_done(input int mode, input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      case (mode)
        0: tx_ready = 1'b1;
        1: tx_ready = (c % 2 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_rd, mem_addr, tx_data, tx_valid, tx_last, busy, done, err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: rd=%b addr=%h data=%h valid=%b last=%b busy=%b done=%b err=%b required all 0",
               mem_rd, mem_addr, tx_data, tx_valid, tx_last, busy, done, err);
    end
    nrst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b valid=%b required 0 0", busy, tx_valid);
    end
  endtask

  task automatic test_heartbeat();
    bit got;
    rd_addrs.delete();
    push_pkt(3'b000, 16'h000C, 16'h0000, 16'h0100, 16'h0000, 16'h0003, '0, 0);
    start_req(3'b000, 16'h000C, 16'h0000, 16'h0100, 16'h0000, 16'h0003, '0, 6'd0);
    checks++;
    if (busy !== 1'b1 || tx_valid !== 1'b1) begin
      failures++;
      $display("FAIL hb_start: busy=%b valid=%b required 1 1", busy, tx_valid);
    end
    run_until_done(0, 40, got);
    checks++;
    if (got !== 1'b1 || busy !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL hb_done: done_seen=%b busy=%b pending=%0d required 1 0 0", got, busy, exp_q.size());
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || rd_addrs.size() != 0) begin
      failures++;
      $display("FAIL hb_done_pulse: done=%b mem_reads=%0d required 0 0", done, rd_addrs.size());
    end
  endtask

  task automatic test_ch_backpressure();
    bit got;
    push_pkt(3'b001, 16'h000C, 16'hFFFF, 16'h0200, 16'h0010, 16'h0001, '0, 0);
    start_req(3'b001, 16'h000C, 16'hFFFF, 16'h0200, 16'h0010, 16'h0001, '0, 6'd0);
    run_until_done(1, 60, got);
    checks++;
    if (got !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL ch_done: done_seen=%b pending=%0d required 1 0", got, exp_q.size());
    end
  endtask

  task automatic test_data_wrap();
    bit got;
    logic [AW-1:0] exp_addr [4];
    exp_addr[0] = 11'h7FE; exp_addr[1] = 11'h7FF; exp_addr[2] = 11'h000; exp_addr[3] = 11'h001;
    mem[11'h7FE] = 8'hAB; mem[11'h7FF] = 8'hCD; mem[11'h000] = 8'h12; mem[11'h001] = 8'h34;
    rd_addrs.delete();
    push_pkt(3'b011, 16'h000C, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 11'h7FE, 2);
    start_req(3'b011, 16'h000C, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 11'h7FE, 6'd2);
    run_until_done(0, 60, got);
    checks++;
    if (got !== 1'b1 || exp_q.size() != 0 || rd_addrs.size() != 4) begin
      failures++;
      $display("FAIL data_done: done_seen=%b pending=%0d reads=%0d required 1 0 4",
               got, exp_q.size(), rd_addrs.size());
    end
    for (int i = 0; i < 4 && i < rd_addrs.size(); i++) begin
      checks++;
      if (rd_addrs[i] !== exp_addr[i]) begin
        failures++;
        $display("FAIL data_mem_addr[%0d]: addr=%h required %h", i, rd_addrs[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [2:0] types [3];
    logic [5:0] wcnt [3];
    types[0] = 3'b111; wcnt[0] = 6'd4;
    types[1] = 3'b011; wcnt[1] = 6'd0;
    types[2] = 3'b011; wcnt[2] = 6'd33;
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_addrs.delete();
      start_req(types[i], 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 11'h010, wcnt[i]);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0 || mem_rd !== 1'b0) begin
        failures++;
        $display("FAIL illegal_reject[%0d]: err=%b busy=%b valid=%b rd=%b required 1 0 0 0",
                 i, err, busy, tx_valid, mem_rd);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (err !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0 || rd_addrs.size() != 0) begin
        failures++;
        $display("FAIL illegal_after[%0d]: err=%b valid=%b busy=%b reads=%0d required 0 0 0 0",
                 i, err, valid_str(tx_valid), busy, rd_addrs.size());
      end
    end
  endtask

  function automatic logic valid_str(input logic v);
    return v;
  endfunction

  task automatic test_busy_ignore();
    bit got;
    push_pkt(3'b000, 16'h00A1, 16'h00B2, 16'h0777, 16'h0000, 16'h0009, '0, 0);
    start_req(3'b000, 16'h00A1, 16'h00B2, 16'h0777, 16'h0000, 16'h0009, '0, 6'd0);
    tx_pkt_type = 3'b001;
    tx_start = 1'b1;
    tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tx_start = 1'b0;
    run_until_done(0, 40, got);
    checks++;
    if (got !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL busy_ignore_done: done_seen=%b pending=%0d required 1 0", got, exp_q.size());
    end
    // Restart in the done cycle
    push_pkt(3'b000, 16'h0042, 16'h0043, 16'h0044, 16'h0000, 16'h0045, '0, 0);
    start_req(3'b000, 16'h0042, 16'h0043, 16'h0044, 16'h0000, 16'h0045, '0, 6'd0);
    checks++;
    if (busy !== 1'b1 || tx_valid !== 1'b1) begin
      failures++;
      $display("FAIL done_cycle_restart: busy=%b valid=%b required 1 1", busy, tx_valid);
    end
    run_until_done(2, 80, got);
    checks++;
    if (got !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL restart_done: done_seen=%b pending=%0d required 1 0", got, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_fetch();
    bit got;
    bit seen;
    for (int i = 0; i < 8; i++) mem[11'h100 + 11'(i)] = 8'(8'h50 + i);
    push_pkt(3'b011, 16'h000C, 16'h0001, '0, '0, '0, 11'h100, 4);
    start_req(3'b011, 16'h000C, 16'h0001, '0, '0, '0, 11'h100, 6'd4);
    tx_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (mem_rd === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL fetch_start: mem_rd_seen=%b required 1", seen);
    end
    #1 nrst = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || mem_rd !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_abort: valid=%b rd=%b busy=%b done=%b required 0 0 0 0",
               tx_valid, mem_rd, busy, done);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: done=%b busy=%b required 0 0", done, busy);
    end
    push_pkt(3'b000, 16'h000C, 16'h0000, 16'h0100, 16'h0000, 16'h0003, '0, 0);
    start_req(3'b000, 16'h000C, 16'h0000, 16'h0100, 16'h0000, 16'h0003, '0, 6'd0);
    run_until_done(0, 40, got);
    checks++;
    if (got !== 1'b1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL post_reset_hb: done_seen=%b pending=%0d required 1 0", got, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    logic [2:0]    t;
    logic [AW-1:0] base;
    logic [5:0]    words;
    logic [15:0]   r [5];
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    for (int p = 0; p < 4; p++) begin
      t     = (p == 0) ? 3'b010 : (p == 1) ? 3'b011 : (p == 2) ? 3'b001 : 3'b011;
      base  = 11'($urandom);
      words = (p == 1) ? 6'd32 : 6'($urandom_range(1, 32));
      for (int k = 0; k < 5; k++) r[k] = 16'($urandom);
      push_pkt(t, r[0], r[1], r[2], r[3], r[4], base, int'(words));
      start_req(t, r[0], r[1], r[2], r[3], r[4], base, words);
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL b2b_start[%0d]: busy=%b required 1", p, busy);
      end
      run_until_done(2, 1500, got);
      checks++;
      if (got !== 1'b1 || exp_q.size() != 0) begin
        failures++;
        $display("FAIL b2b_done[%0d]: done_seen=%b pending=%0d required 1 0", p, got, exp_q.size());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    test_reset();
    test_heartbeat();
    test_ch_backpressure();
    test_data_wrap();
    test_illegal();
    test_busy_ignore();
    test_reset_mid_fetch();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
